// File: rtl/vga_fb_reader.sv
// vga_fb_reader
//   Generates VGA timing from a single pixel clock and streams a 4-bit
//   grayscale frame buffer to the pins.
//
//   Stage 0 holds the raster position and the linear pixel address.
//   Stage 1 presents fb_addr/fb_re to the frame buffer.
//   Stage 2 is where fb_rdata is valid.
//   Stage 3 is the output register.
//   Pixels therefore reach the pins 3 cycles after their raster position.
//   The sync and marker signals are delayed through the same three
//   registers, so they stay aligned with the data.
//
// Ports
//   clk25        pixel clock, the only clock
//   rst          synchronous, active-high reset
//   fb_addr      frame-buffer read address (linear pixel index)
//   fb_re        frame-buffer read enable (high for visible pixels)
//   fb_rdata     frame-buffer read data, valid one cycle after fb_addr
//   vga_r/g/b    pixel colour; the gray level is copied to all three, 0 in blanking
//   vga_hs/vs    sync pulses, active low
//   de           display enable, aligned with vga_r/g/b
//   frame_start  one-cycle pulse while pixel (0,0) is at the pins
module vga_fb_reader #(
  parameter int width  = 640,
  parameter int height = 480,
  parameter int h_fp   = 16,
  parameter int h_sync = 96,
  parameter int h_bp   = 48,
  parameter int v_fp   = 10,
  parameter int v_sync = 2,
  parameter int v_bp   = 33
) (
  input  logic        clk25,
  input  logic        rst,
  output logic [18:0] fb_addr,
  output logic        fb_re,
  input  logic [3:0]  fb_rdata,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        de,
  output logic        frame_start
);

  localparam int H_TOT = width + h_fp + h_sync + h_bp;
  localparam int V_TOT = height + v_fp + v_sync + v_bp;
  // One extra count of headroom keeps the sync end compare representable.
  localparam int HW = $clog2(H_TOT + 1);
  localparam int VW = $clog2(V_TOT + 1);

  localparam logic [HW-1:0] H_VIS  = HW'(width);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(width + h_fp);
  localparam logic [HW-1:0] HS_END = HW'(width + h_fp + h_sync);
  localparam logic [VW-1:0] V_VIS  = VW'(height);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(height + v_fp);
  localparam logic [VW-1:0] VS_END = VW'(height + v_fp + v_sync);
  localparam logic [18:0]   A_LAST = 19'(width * height - 1);

  // Stage 0: raster position and address counter
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [18:0]   addr_q, addr_d;
  logic          visible_s, hs0_s, vs0_s, fs0_s, h_wrap_s;

  // Stage 1: frame-buffer request plus delayed timing
  logic [18:0]   fb_addr_q, fb_addr_d;
  logic          fb_re_q, fb_re_d;
  logic          hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;

  // Stage 2: read data valid
  logic          vis2_q, vis2_d, hs2_q, hs2_d, vs2_q, vs2_d, fs2_q, fs2_d;

  // Stage 3: pins
  logic [3:0]    pix_q, pix_d;
  logic          de_q, de_d, hs3_q, hs3_d, vs3_q, vs3_d, fs3_q, fs3_d;

  // Decode the stage-0 raster position into visible/sync/frame-origin flags.
  always_comb begin
    h_wrap_s  = (h_cnt_q == H_LAST);
    visible_s = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs0_s     = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs0_s     = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    fs0_s     = (h_cnt_q == HW'(0)) && (v_cnt_q == VW'(0));
  end

  // Next raster position and next linear address.
  always_comb begin
    if (h_wrap_s) begin
      h_cnt_d = HW'(0);
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = VW'(0);
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
    end

    // Step through the frame one visible pixel at a time (no multiplier).
    // Wrapping on the last pixel keeps the counter inside the frame, and the
    // vertical-blank clear guarantees every frame starts from 0 even after a
    // mid-frame reset.
    if (visible_s) begin
      if (addr_q == A_LAST) begin
        addr_d = 19'd0;
      end else begin
        addr_d = addr_q + 19'd1;
      end
    end else if (v_cnt_q >= V_VIS) begin
      addr_d = 19'd0;
    end else begin
      addr_d = addr_q;
    end
  end

  // Advance the three pipeline stages; only stage 3 looks at fb_rdata.
  always_comb begin
    fb_addr_d = addr_q;
    fb_re_d   = visible_s;
    hs1_d     = hs0_s;
    vs1_d     = vs0_s;
    fs1_d     = fs0_s;

    vis2_d    = fb_re_q;
    hs2_d     = hs1_q;
    vs2_d     = vs1_q;
    fs2_d     = fs1_q;

    de_d      = vis2_q;
    hs3_d     = hs2_q;
    vs3_d     = vs2_q;
    fs3_d     = fs2_q;
    if (vis2_q) begin
      pix_d = fb_rdata;
    end else begin
      pix_d = 4'd0;
    end
  end

  // State and pipeline registers; reset parks the raster at (0,0) with syncs inactive.
  always_ff @(posedge clk25) begin
    if (rst) begin
      h_cnt_q   <= HW'(0);
      v_cnt_q   <= VW'(0);
      addr_q    <= 19'd0;
      fb_addr_q <= 19'd0;
      fb_re_q   <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      fs1_q     <= 1'b0;
      vis2_q    <= 1'b0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      fs2_q     <= 1'b0;
      pix_q     <= 4'd0;
      de_q      <= 1'b0;
      hs3_q     <= 1'b1;
      vs3_q     <= 1'b1;
      fs3_q     <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      addr_q    <= addr_d;
      fb_addr_q <= fb_addr_d;
      fb_re_q   <= fb_re_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      fs1_q     <= fs1_d;
      vis2_q    <= vis2_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      fs2_q     <= fs2_d;
      pix_q     <= pix_d;
      de_q      <= de_d;
      hs3_q     <= hs3_d;
      vs3_q     <= vs3_d;
      fs3_q     <= fs3_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_re       = fb_re_q;
  assign vga_r       = pix_q;
  assign vga_g       = pix_q;
  assign vga_b       = pix_q;
  assign vga_hs      = hs3_q;
  assign vga_vs      = vs3_q;
  assign de          = de_q;
  assign frame_start = fs3_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader
//   Runs a reduced-size raster so that whole frames stay short.
//   Memory model: mem[a] = a[3:0], with a registered (1-cycle) read.
//   A reference raster position is advanced alongside the DUT.
//   Each cycle, the pin values expected for that position are pushed to a
//   queue and compared three cycles later, when the DUT presents them.
module tb_vga_fb_reader;

  localparam int W   = 16;
  localparam int H   = 4;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 2;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int HT  = W + HFP + HSW + HBP;
  localparam int VT  = H + VFP + VSW + VBP;
  localparam int FR  = HT * VT;

  logic        clk25 = 1'b0;
  logic        rst   = 1'b1;
  logic [18:0] fb_addr;
  logic        fb_re;
  logic [3:0]  fb_rdata;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, de, frame_start;
  logic [3:0]  mem_q   = 4'd0;
  logic        force_f = 1'b0;

  always #5 clk25 = ~clk25;

  // Frame-buffer model: data for an address appears one cycle later.
  always @(posedge clk25) mem_q <= fb_addr[3:0];
  assign fb_rdata = force_f ? 4'hF : mem_q;

  vga_fb_reader #(
    .width(W), .height(H), .h_fp(HFP), .h_sync(HSW), .h_bp(HBP),
    .v_fp(VFP), .v_sync(VSW), .v_bp(VBP)
  ) dut (
    .clk25(clk25), .rst(rst), .fb_addr(fb_addr), .fb_re(fb_re),
    .fb_rdata(fb_rdata), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .de(de), .frame_start(frame_start)
  );

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [3:0] pix;
  } exp_t;

  localparam exp_t RESET_ENTRY = '{de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, pix: 4'd0};

  exp_t        exp_q[$];
  int          n_asserts = 0;
  int          n_fail    = 0;
  int          hm, vm, cyc;
  logic        prev_re, prev_vblank;
  logic [18:0] prev_addr;
  logic        stats_en = 1'b0;
  logic        prev_hs_pin, prev_vs_pin;
  int          de_cnt = 0, hs_low = 0, vs_low = 0, fs_cnt = 0;
  int          fs_first = -1, fs_last = -1, fs_period = -1;
  int          hs_first = -1, hs_last = -1, hs_period = -1;
  int          vs_first = -1, vs_last = -1, vs_period = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  // Counters sit at (0,0) in the current cycle; the pins still show reset values.
  task automatic release_init();
    exp_q.delete();
    repeat (3) exp_q.push_back(RESET_ENTRY);
    hm = 0;
    vm = 0;
    cyc = 0;
    prev_re = 1'b0;
    prev_addr = 19'd0;
    prev_vblank = 1'b0;
    prev_hs_pin = 1'b1;
    prev_vs_pin = 1'b1;
  endtask

  task automatic check_reset_pins();
    check_eq("rst_de", de, 1'b0);
    check_eq("rst_hs", vga_hs, 1'b1);
    check_eq("rst_vs", vga_vs, 1'b1);
    check_eq("rst_fs", frame_start, 1'b0);
    check_eq("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check_eq("rst_fb_re", fb_re, 1'b0);
    check_eq("rst_fb_addr", fb_addr, 19'd0);
  endtask

  task automatic observe();
    exp_t e, got;
    logic vis;
    int   idx;
    check_eq("fb_re", fb_re, prev_re);
    if (prev_re || prev_vblank) check_eq("fb_addr", fb_addr, prev_addr);

    vis   = (hm < W) && (vm < H);
    idx   = vm * W + hm;
    e.de  = vis;
    e.hs  = !((hm >= W + HFP) && (hm < W + HFP + HSW));
    e.vs  = !((vm >= H + VFP) && (vm < H + VFP + VSW));
    e.fs  = (hm == 0) && (vm == 0);
    e.pix = !vis ? 4'd0 : (force_f ? 4'hF : idx[3:0]);
    exp_q.push_back(e);

    got = exp_q.pop_front();
    check_eq("de", de, got.de);
    check_eq("vga_hs", vga_hs, got.hs);
    check_eq("vga_vs", vga_vs, got.vs);
    check_eq("frame_start", frame_start, got.fs);
    check_eq("vga_r", vga_r, got.pix);
    check_eq("vga_g", vga_g, got.pix);
    check_eq("vga_b", vga_b, got.pix);

    // Pin statistics over exactly two frames of raster positions.
    if (stats_en && cyc >= 3 && cyc < 3 + 2 * FR) begin
      if (de) de_cnt++;
      if (!vga_hs) hs_low++;
      if (!vga_vs) vs_low++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = cyc;
        if (fs_last >= 0) fs_period = cyc - fs_last;
        fs_last = cyc;
      end
      if (prev_hs_pin && !vga_hs) begin
        if (hs_first < 0) hs_first = cyc;
        if (hs_last >= 0) hs_period = cyc - hs_last;
        hs_last = cyc;
      end
      if (prev_vs_pin && !vga_vs) begin
        if (vs_first < 0) vs_first = cyc;
        if (vs_last >= 0) vs_period = cyc - vs_last;
        vs_last = cyc;
      end
    end
    prev_hs_pin = vga_hs;
    prev_vs_pin = vga_vs;

    prev_re     = vis;
    prev_addr   = vis ? 19'(idx) : 19'd0;
    prev_vblank = (vm >= H);
    if (hm == HT - 1) begin
      hm = 0;
      vm = (vm == VT - 1) ? 0 : vm + 1;
    end else begin
      hm++;
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    force_f = 1'b0;
    repeat (3) begin
      tick();
      check_reset_pins();
    end

    // Release: this cycle is the first one with counters at (0,0).
    rst = 1'b0;
    release_init();
    stats_en = 1'b1;
    for (int i = 0; i < 2 * FR + 10; i++) begin
      observe();
      tick();
    end
    stats_en = 1'b0;

    check_eq("de_per_2frames", de_cnt, 2 * W * H);
    check_eq("hs_low_cycles", hs_low, 2 * VT * HSW);
    check_eq("vs_low_cycles", vs_low, 2 * VSW * HT);
    check_eq("hs_first_fall", hs_first, W + HFP + 3);
    check_eq("hs_period", hs_period, HT);
    check_eq("vs_first_fall", vs_first, (H + VFP) * HT + 3);
    check_eq("vs_period", vs_period, FR);
    check_eq("fs_count", fs_cnt, 2);
    check_eq("fs_first", fs_first, 3);
    check_eq("fs_period", fs_period, FR);

    // Run on to a visible mid-frame position, then pulse reset for one cycle.
    for (int i = 0; i < FR && !(hm == 5 && vm == 2); i++) begin
      observe();
      tick();
    end
    observe();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_f = 1'b1;
    check_reset_pins();
    release_init();
    for (int i = 0; i < 2 * FR + 10; i++) begin
      observe();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
